// File: rtl/iir_pkg.sv
// Shared types and arithmetic helpers for the biquad cascade.
// The helpers work on a 64-bit signed value. The accumulator
// (DATA_W+COEF_W+3 bits) must therefore fit in 64 bits.
package iir_pkg;

    localparam int NCOEF  = 5;
    localparam int WIDE_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_UPD  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    // Coefficient slot inside one section: address = sect*NCOEF + index
    typedef enum logic [2:0] {
        CK_B0 = 3'd0,
        CK_B1 = 3'd1,
        CK_B2 = 3'd2,
        CK_A1 = 3'd3,
        CK_A2 = 3'd4
    } coef_idx_e;

    typedef logic signed [WIDE_W-1:0] wide_t;

    // Accumulator width that holds five full products without wrapping
    function automatic int acc_width(input int data_w, input int coef_w);
        return data_w + coef_w + 3;
    endfunction

    // Round half up, then drop the fractional bits
    function automatic wide_t round_shift(input wide_t v, input int frac);
        wide_t half;
        half = wide_t'(1) <<< (frac - 1);
        return (v + half) >>> frac;
    endfunction

    function automatic wide_t sat_hi(input int data_w);
        return (wide_t'(1) <<< (data_w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_lo(input int data_w);
        return -(wide_t'(1) <<< (data_w - 1));
    endfunction

    function automatic logic sat_needed(input wide_t v, input int data_w);
        return (v > sat_hi(data_w)) || (v < sat_lo(data_w));
    endfunction

    function automatic wide_t saturate(input wide_t v, input int data_w);
        if (v > sat_hi(data_w)) return sat_hi(data_w);
        if (v < sat_lo(data_w)) return sat_lo(data_w);
        return v;
    endfunction

endpackage

// File: rtl/iir_biquad_cascade_if.sv
// Sample stream and coefficient-write bus of the biquad cascade.
// Handshake: a transfer happens on a rising clk edge where valid and
// ready are both high. A source holds valid and its data stable until
// that edge. ready may depend on the current state and on the clear
// input, but never on valid.
interface iir_biquad_cascade_if #(
    parameter int DATA_W = 24,
    parameter int COEF_W = 24,
    parameter int ADDR_W = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     coef_we;
    logic        [ADDR_W-1:0] coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/iir_mac.sv
// Shared multiply-accumulate for all taps and sections. It also provides
// the rounded and saturated view of the accumulator plus a clamp flag.
module iir_mac
    import iir_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int COEF_W = 24,
    parameter int FRAC_W = 20
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic                     i_sub,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [COEF_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_y,
    output logic                     o_sat
);
    localparam int ACC_W  = acc_width(DATA_W, COEF_W);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  r_acc;
    wide_t                    w_wide;
    wide_t                    w_rs;

    assign w_prod     = PROD_W'(i_a) * PROD_W'(i_b);
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // Accumulate or subtract one product per enabled cycle; clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  r_acc <= '0;
        else if (i_clr) r_acc <= '0;
        else if (i_en)  r_acc <= i_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
    end

    assign w_wide = {{(WIDE_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_rs   = round_shift(w_wide, FRAC_W);
    assign o_sat  = sat_needed(w_rs, DATA_W);
    assign o_y    = DATA_W'(saturate(w_rs, DATA_W));
endmodule

// File: rtl/iir_biquad_cascade.sv
// Time-multiplexed cascade of N_SECT direct-form-I biquads. One sample is
// in flight at a time. Each section takes five MAC cycles and one update
// cycle, so the output appears 6*N_SECT cycles after acceptance.
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int COEF_W = 24,
    parameter int FRAC_W = 20,
    parameter int N_SECT = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    iir_biquad_cascade_if.slave bus,
    output logic              sat_flag,
    output logic [1:0]        o_dbg_state
);
    localparam int NC     = NCOEF * N_SECT;
    localparam int ADDR_W = $clog2(NC);
    localparam int SECT_W = (N_SECT > 1) ? $clog2(N_SECT) : 1;

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_MAC  = 2'(ST_MAC);
    localparam logic [1:0] S_UPD  = 2'(ST_UPD);
    localparam logic [1:0] S_OUT  = 2'(ST_OUT);

    localparam logic signed [COEF_W-1:0] C_ONE = COEF_W'(1) << FRAC_W;

    logic [1:0]               r_state;
    logic [SECT_W-1:0]        r_sect;
    logic [2:0]               r_k;
    logic signed [DATA_W-1:0] r_x;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_sat;
    logic signed [COEF_W-1:0] r_coef [NC];
    logic signed [DATA_W-1:0] r_x1 [N_SECT];
    logic signed [DATA_W-1:0] r_x2 [N_SECT];
    logic signed [DATA_W-1:0] r_y1 [N_SECT];
    logic signed [DATA_W-1:0] r_y2 [N_SECT];

    logic                     w_accept;
    logic                     w_last;
    logic [ADDR_W-1:0]        w_cidx;
    logic signed [DATA_W-1:0] w_mac_a;
    logic signed [COEF_W-1:0] w_mac_b;
    logic                     w_mac_sub;
    logic                     w_mac_clr;
    logic                     w_mac_en;
    logic signed [DATA_W-1:0] w_y;
    logic                     w_sat;

    assign bus.in_ready  = (r_state == S_IDLE) && !clear;
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.out_data  = r_out_data;
    assign sat_flag      = r_sat;
    assign o_dbg_state   = r_state;

    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_last    = (r_sect == SECT_W'(N_SECT - 1));
    assign w_cidx    = ADDR_W'(r_sect) * ADDR_W'(NCOEF) + ADDR_W'(r_k);
    assign w_mac_clr = clear || w_accept || (r_state == S_UPD);
    assign w_mac_en  = (r_state == S_MAC);

    // Select the delay-line operand for the current tap; feedback taps subtract
    always_comb begin
        w_mac_a   = r_x;
        w_mac_b   = r_coef[w_cidx];
        w_mac_sub = 1'b0;
        case (coef_idx_e'(r_k))
            CK_B1: w_mac_a = r_x1[r_sect];
            CK_B2: w_mac_a = r_x2[r_sect];
            CK_A1: begin
                w_mac_a   = r_y1[r_sect];
                w_mac_sub = 1'b1;
            end
            CK_A2: begin
                w_mac_a   = r_y2[r_sect];
                w_mac_sub = 1'b1;
            end
            default: ;
        endcase
    end

    iir_mac #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .FRAC_W(FRAC_W)
    ) u_mac (
        .clk    (clk),
        .reset_n(reset_n),
        .i_clr  (w_mac_clr),
        .i_en   (w_mac_en),
        .i_sub  (w_mac_sub),
        .i_a    (w_mac_a),
        .i_b    (w_mac_b),
        .o_y    (w_y),
        .o_sat  (w_sat)
    );

    // Sequencer: accept, five taps per section, update, present output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_sect     <= '0;
            r_k        <= '0;
            r_x        <= '0;
            r_out_data <= '0;
        end else if (clear) begin
            r_state    <= S_IDLE;
            r_sect     <= '0;
            r_k        <= '0;
            r_x        <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x     <= bus.in_data;
                        r_sect  <= '0;
                        r_k     <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (r_k == 3'(NCOEF - 1)) r_state <= S_UPD;
                    else                      r_k     <= r_k + 3'd1;
                end
                S_UPD: begin
                    r_k <= '0;
                    if (w_last) begin
                        r_out_data <= w_y;
                        r_state    <= S_OUT;
                    end else begin
                        r_sect  <= r_sect + SECT_W'(1);
                        r_x     <= w_y;
                        r_state <= S_MAC;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Per-section delay lines shift once per section update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || clear) begin
            for (int s = 0; s < N_SECT; s++) begin
                r_x1[s] <= '0;
                r_x2[s] <= '0;
                r_y1[s] <= '0;
                r_y2[s] <= '0;
            end
        end else if (r_state == S_UPD) begin
            r_x2[r_sect] <= r_x1[r_sect];
            r_x1[r_sect] <= r_x;
            r_y2[r_sect] <= r_y1[r_sect];
            r_y1[r_sect] <= w_y;
        end
    end

    // Sticky clamp indication, dropped only by clear or reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                       r_sat <= 1'b0;
        else if (clear)                     r_sat <= 1'b0;
        else if (r_state == S_UPD && w_sat) r_sat <= 1'b1;
    end

    // Coefficient file: passthrough after reset, writable only while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NC; i++)
                r_coef[i] <= (i % NCOEF == 0) ? C_ONE : '0;
        end else if (!clear && bus.coef_we && r_state == S_IDLE
                     && int'(bus.coef_addr) < NC) begin
            r_coef[bus.coef_addr] <= bus.coef_wdata;
        end
    end
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Bench for iir_biquad_cascade: constant vector table, hand-written corner
// sequences and randomized samples against a floating-free reference model.
module tb_iir_biquad_cascade;
    import iir_pkg::*;

    localparam int DATA_W = 24;
    localparam int COEF_W = 24;
    localparam int FRAC_W = 20;
    localparam int N_SECT = 3;
    localparam int NC     = NCOEF * N_SECT;
    localparam int ADDR_W = $clog2(NC);
    localparam int LAT    = 6 * N_SECT;

    localparam longint ONE  = longint'(1) <<< FRAC_W;
    localparam longint DMAX = (longint'(1) <<< (DATA_W - 1)) - 1;
    localparam longint DMIN = -(longint'(1) <<< (DATA_W - 1));

    // ---------------- clock / reset ----------------
    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear   = 1'b0;
    logic       sat_flag;
    logic [1:0] dbg_state;

    iir_biquad_cascade_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(ADDR_W)) bus ();

    iir_biquad_cascade #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .FRAC_W(FRAC_W),
        .N_SECT(N_SECT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .bus        (bus),
        .sat_flag   (sat_flag),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_coef [NC];
    longint m_x1 [N_SECT];
    longint m_x2 [N_SECT];
    longint m_y1 [N_SECT];
    longint m_y2 [N_SECT];
    bit     m_sat;

    function automatic void model_reset_coefs();
        for (int i = 0; i < NC; i++) m_coef[i] = (i % 5 == 0) ? ONE : 0;
    endfunction

    function automatic void model_clear_state();
        for (int s = 0; s < N_SECT; s++) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
        m_sat = 0;
    endfunction

    function automatic longint model_sample(input longint x);
        longint v, acc, y;
        v = x;
        for (int s = 0; s < N_SECT; s++) begin
            acc = m_coef[5*s] * v + m_coef[5*s+1] * m_x1[s] + m_coef[5*s+2] * m_x2[s]
                - m_coef[5*s+3] * m_y1[s] - m_coef[5*s+4] * m_y2[s];
            y = (acc + (longint'(1) <<< (FRAC_W - 1))) >>> FRAC_W;
            if (y > DMAX) begin y = DMAX; m_sat = 1; end
            if (y < DMIN) begin y = DMIN; m_sat = 1; end
            m_x2[s] = m_x1[s]; m_x1[s] = v;
            m_y2[s] = m_y1[s]; m_y1[s] = y;
            v = y;
        end
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic write_coef(input int addr, input longint val);
        @(negedge clk);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = ADDR_W'(addr);
        bus.coef_wdata = COEF_W'(val);
        m_coef[addr]   = val;
        @(negedge clk);
        bus.coef_we    = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear_state();
    endtask

    // Presents a sample (optionally with a same-cycle coefficient write)
    // and returns #1 after the accepting edge.
    task automatic start_sample(input longint din, input bit with_we,
                                input int we_addr, input longint we_val);
        int guard;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(din);
        if (with_we) begin
            bus.coef_we      = 1'b1;
            bus.coef_addr    = ADDR_W'(we_addr);
            bus.coef_wdata   = COEF_W'(we_val);
            m_coef[we_addr]  = we_val;
        end
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard == 50) check("accept_timeout", guard, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
    endtask

    // Waits for the output, optionally stalls it, then completes the handshake.
    task automatic collect(input string nm, input int elapsed, input int hold,
                           output longint dout);
        int lat;
        lat = elapsed;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_latency"}, lat, LAT);
        dout = longint'(bus.out_data);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(4321);
            @(posedge clk);
            #1;
            check({nm, "_hold_data"}, longint'(bus.out_data), dout);
            check({nm, "_hold_in_ready"}, bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({nm, "_idle_state"}, dbg_state, 0);
        check({nm, "_idle_in_ready"}, bus.in_ready, 1);
        check({nm, "_idle_out_valid"}, bus.out_valid, 0);
    endtask

    task automatic run_chk(input string nm, input longint din, input int hold);
        longint got;
        exp_q.push_back(DATA_W'(model_sample(din)));
        start_sample(din, 1'b0, 0, 0);
        collect(nm, 0, hold, got);
        check({nm, "_data"}, got, longint'($signed(exp_q.pop_front())));
        check({nm, "_sat"}, sat_flag, m_sat);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int     addr;
        longint coef;
        longint din;
        longint exp_out;
        bit     exp_sat;
    } vec_t;

    vec_t tbl [6];

    initial begin
        longint got;
        int     nv;
        longint rec_in  [4];
        longint rec_exp [4];

        tbl[0] = '{0, ONE,     1000,    1000,  1'b0};
        tbl[1] = '{0, ONE/2,   1000,    500,   1'b0};
        tbl[2] = '{0, ONE/2,   -1001,   -500,  1'b0};
        tbl[3] = '{0, ONE/2,   1001,    501,   1'b0};
        tbl[4] = '{0, ONE,     DMIN,    DMIN,  1'b0};
        tbl[5] = '{0, ONE*4,   3000000, DMAX,  1'b1};
        rec_in  = '{1024, 0, 0, 0};
        rec_exp = '{1024, 512, 256, 128};

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        model_reset_coefs();
        model_clear_state();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", longint'(bus.out_data), 0);
        check("rst_sat_flag", sat_flag, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Passthrough straight out of reset
        void'(model_sample(1000));
        start_sample(1000, 1'b0, 0, 0);
        collect("pass_reset", 0, 0, got);
        check("pass_reset_data", got, 1000);
        check("pass_reset_sat", sat_flag, 0);

        // Table: gain, rounding, extremes, saturation
        for (int i = 0; i < 6; i++) begin
            pulse_clear();
            write_coef(tbl[i].addr, tbl[i].coef);
            void'(model_sample(tbl[i].din));
            start_sample(tbl[i].din, 1'b0, 0, 0);
            collect($sformatf("vec%0d", i), 0, 0, got);
            check($sformatf("vec%0d_data", i), got, tbl[i].exp_out);
            check($sformatf("vec%0d_sat", i), sat_flag, tbl[i].exp_sat);
        end

        // Clear drops the sticky flag
        pulse_clear();
        check("clear_sat_flag", sat_flag, 0);

        // Same-cycle write and accept: new b0 applies to this sample
        start_sample(1000, 1'b1, 0, ONE/2);
        void'(model_sample(1000));
        collect("same_cycle_we", 0, 0, got);
        check("same_cycle_we_data", got, 500);

        // Recursion through a1 = -0.5
        write_coef(0, ONE);
        write_coef(3, -524288);
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            void'(model_sample(rec_in[i]));
            start_sample(rec_in[i], 1'b0, 0, 0);
            collect($sformatf("rec%0d", i), 0, 0, got);
            check($sformatf("rec%0d_data", i), got, rec_exp[i]);
        end
        write_coef(3, 0);

        // Backpressure for 10 cycles
        run_chk("bp", 1234, 10);

        // Clear mid-operation; b1 makes stale history visible
        write_coef(1, ONE);
        run_chk("prime", 3000, 0);
        start_sample(5000, 1'b0, 0, 0);
        repeat (7) @(posedge clk);
        pulse_clear();
        nv = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) nv++;
        end
        check("midclear_no_output", nv, 0);
        check("midclear_state", dbg_state, 0);
        void'(model_sample(1000));
        start_sample(1000, 1'b0, 0, 0);
        collect("midclear_next", 0, 0, got);
        check("midclear_next_data", got, 1000);
        write_coef(1, 0);

        // Coefficient write during MAC is ignored
        void'(model_sample(777));
        start_sample(777, 1'b0, 0, 0);
        @(negedge clk);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        @(negedge clk);
        bus.coef_we    = 1'b0;
        collect("mac_we", 1, 0, got);
        check("mac_we_data", got, 777);
        run_chk("mac_we_after", 1000, 0);

        // Reset pulse mid-MAC restores reset values and passthrough
        write_coef(0, ONE/2);
        start_sample(1000, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data", longint'(bus.out_data), 0);
        check("midrst_sat", sat_flag, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset_coefs();
        model_clear_state();
        nv = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) nv++;
        end
        check("midrst_no_output", nv, 0);
        run_chk("post_rst", 1000, 0);

        // Randomized coefficients, samples, stalls and clears
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                write_coef(int'($urandom_range(0, NC - 1)),
                           longint'($urandom_range(0, 2 * ONE)) - ONE);
            if ($urandom_range(0, 7) == 0)
                pulse_clear();
            run_chk($sformatf("rnd%0d", i),
                    longint'($urandom_range(0, (1 << DATA_W) - 1)) + DMIN,
                    int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
